pte_cache_array: RTL and testbench

- 8-entry fully associative PTE cache storage and tag-match stage of the page table walker.
- Holds tag/valid/PPN per entry, matches lookups, and selects the fill victim.
- Drives the per-entry hit vector, victim index and stored PPNs consumed directly by cache_search_unit.
- The downstream stage forwards the in-flight fill PPN when the hit index equals replace_entry. This block keeps hit_bit consistent with that forwarding rule.

---
 rtl/pte_cache_pkg.sv | 15 +
 rtl/pte_cache_victim_sel.sv | 38 +++
 rtl/pte_cache_array.sv | 77 +++++++
 tb/tb_pte_cache_array.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pte_cache_pkg.sv
// pte_cache_pkg: shared constants and storage types for the PTE cache
package pte_cache_pkg;
  localparam int PTE_CACHE_ENTRIES = 8;
  localparam int PTE_CACHE_IDX_W = 3;
  localparam int PTE_TAG_W = 29;
  localparam int PTE_PPN_W = 20;
  typedef logic [PTE_TAG_W-1:0] pte_tag_t;
  typedef logic [PTE_PPN_W-1:0] pte_ppn_t;
  typedef logic [PTE_CACHE_IDX_W-1:0] pte_idx_t;
  typedef struct packed {
    logic     valid;
    pte_tag_t tag;
    pte_ppn_t ppn;
  } pte_entry_t;
endpackage

// File: rtl/pte_cache_victim_sel.sv
// pte_cache_victim_sel: fill slot choice (duplicate, first invalid, round-robin) and rr pointer
module pte_cache_victim_sel
  import pte_cache_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PTE_CACHE_ENTRIES-1:0]         valid,
  input  pte_tag_t [PTE_CACHE_ENTRIES-1:0]     tags,
  input  pte_tag_t                             fill_tag,
  input  logic                                 fill_acc,
  output pte_idx_t                             victim_idx
);
  pte_idx_t rr_ptr_q, rr_ptr_d, dup_idx, inv_idx;
  logic dup_hit, inv_hit;
  // scan downwards so the lowest matching index wins; pointer only moves on a true eviction
  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    inv_hit = 1'b0;
    inv_idx = '0;
    for (int i = PTE_CACHE_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == fill_tag) begin
        dup_hit = 1'b1;
        dup_idx = PTE_CACHE_IDX_W'(i);
      end
      if (!valid[i]) begin
        inv_hit = 1'b1;
        inv_idx = PTE_CACHE_IDX_W'(i);
      end
    end
    victim_idx = dup_hit ? dup_idx : inv_hit ? inv_idx : rr_ptr_q;
    rr_ptr_d = (fill_acc && !dup_hit && !inv_hit) ? rr_ptr_q + 1'b1 : rr_ptr_q;
  end
  // round-robin pointer register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
endmodule

// File: rtl/pte_cache_array.sv
// pte_cache_array: 8-entry fully associative PTE storage with tag match and fill bypass
module pte_cache_array
  import pte_cache_pkg::*;
#(
  parameter int ENTRIES = PTE_CACHE_ENTRIES,
  parameter int TAG_W = PTE_TAG_W,
  parameter int PPN_W = PTE_PPN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lookup_valid,
  input  logic [TAG_W-1:0]   lookup_tag,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [PPN_W-1:0]   fill_ppn,
  input  logic               flush,
  output logic [ENTRIES-1:0] hit_bit,
  output logic               hit,
  output logic [2:0]         replace_entry,
  output logic [PPN_W-1:0]   ppn_0,
  output logic [PPN_W-1:0]   ppn_1,
  output logic [PPN_W-1:0]   ppn_2,
  output logic [PPN_W-1:0]   ppn_3,
  output logic [PPN_W-1:0]   ppn_4,
  output logic [PPN_W-1:0]   ppn_5,
  output logic [PPN_W-1:0]   ppn_6,
  output logic [PPN_W-1:0]   ppn_7,
  output logic [ENTRIES-1:0] valid_bits
);
  pte_entry_t entries_q [ENTRIES];
  pte_entry_t entries_d [ENTRIES];
  pte_tag_t [ENTRIES-1:0] tag_vec;
  logic [ENTRIES-1:0] raw, repl_oh;
  logic fill_acc;
  pte_idx_t replace_idx;
  assign fill_ready = ~flush;
  assign fill_acc = fill_valid & fill_ready;
  assign replace_entry = replace_idx;
  assign hit = |hit_bit;
  assign {ppn_7, ppn_6, ppn_5, ppn_4} = {entries_q[7].ppn, entries_q[6].ppn, entries_q[5].ppn, entries_q[4].ppn};
  assign {ppn_3, ppn_2, ppn_1, ppn_0} = {entries_q[3].ppn, entries_q[2].ppn, entries_q[1].ppn, entries_q[0].ppn};
  pte_cache_victim_sel u_victim_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid_bits),
    .tags      (tag_vec),
    .fill_tag  (fill_tag),
    .fill_acc  (fill_acc),
    .victim_idx(replace_idx)
  );
  // tag match; a same-cycle fill either bypasses to its slot or masks the slot it evicts
  always_comb begin
    repl_oh = '0;
    repl_oh[replace_idx] = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_bits[i] = entries_q[i].valid;
      tag_vec[i] = entries_q[i].tag;
      raw[i] = lookup_valid & entries_q[i].valid & (entries_q[i].tag == lookup_tag);
    end
    hit_bit = (!lookup_valid || flush) ? '0 :
              !fill_acc ? raw :
              (fill_tag == lookup_tag) ? repl_oh : raw & ~repl_oh;
  end
  // next storage: flush clears valids only, an accepted fill overwrites the chosen slot
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (flush) entries_d[i].valid = 1'b0;
      else if (fill_acc && replace_idx == PTE_CACHE_IDX_W'(i)) entries_d[i] = '{valid: 1'b1, tag: fill_tag, ppn: fill_ppn};
    end
  end
  // storage registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    else entries_q <= entries_d;
endmodule

// File: tb/tb_pte_cache_array.sv
// tb_pte_cache_array: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_pte_cache_array;
  localparam int F_HB = 0, F_HIT = 1, F_REP = 2, F_VB = 3, F_FR = 4, F_PPN = 5;
  typedef struct {int f; int idx; logic [31:0] v;} exp_t;
  exp_t sb [$];
  int pass_cnt = 0, total_cnt = 0;
  logic clk = 0, rst_n = 0;
  logic lookup_valid = 0, fill_valid = 0, flush = 0;
  logic [28:0] lookup_tag = '0, fill_tag = '0;
  logic [19:0] fill_ppn = '0;
  logic fill_ready, hit;
  logic [7:0] hit_bit, valid_bits;
  logic [2:0] replace_entry;
  logic [19:0] ppn_0, ppn_1, ppn_2, ppn_3, ppn_4, ppn_5, ppn_6, ppn_7;

  pte_cache_array dut (
    .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_tag(lookup_tag),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_tag(fill_tag), .fill_ppn(fill_ppn),
    .flush(flush), .hit_bit(hit_bit), .hit(hit), .replace_entry(replace_entry),
    .ppn_0(ppn_0), .ppn_1(ppn_1), .ppn_2(ppn_2), .ppn_3(ppn_3),
    .ppn_4(ppn_4), .ppn_5(ppn_5), .ppn_6(ppn_6), .ppn_7(ppn_7), .valid_bits(valid_bits)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int f, input int idx);
    case (f)
      F_HB: return 32'(hit_bit);
      F_HIT: return 32'(hit);
      F_REP: return 32'(replace_entry);
      F_VB: return 32'(valid_bits);
      F_FR: return 32'(fill_ready);
      default: case (idx)
        0: return 32'(ppn_0);
        1: return 32'(ppn_1);
        2: return 32'(ppn_2);
        3: return 32'(ppn_3);
        4: return 32'(ppn_4);
        5: return 32'(ppn_5);
        6: return 32'(ppn_6);
        default: return 32'(ppn_7);
      endcase
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_HB: return "hit_bit";
      F_HIT: return "hit";
      F_REP: return "replace_entry";
      F_VB: return "valid_bits";
      F_FR: return "fill_ready";
      default: return "ppn";
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, idx, $time, act, want);
  endtask

  always @(negedge clk) begin
    chk("onehot_hit_bit", 0, 32'($countones(hit_bit) <= 1), 32'd1);
    chk("hit_is_or", 0, 32'(hit), 32'(|hit_bit));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(fname(e.f), e.idx, actual(e.f, e.idx), e.v);
    end
  end

  task automatic expect_v(input int f, input int idx, input logic [31:0] v);
    exp_t e;
    e.f = f;
    e.idx = idx;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic step(input logic lv, input logic [28:0] lt, input logic fv, input logic [28:0] ft, input logic [19:0] fp, input logic fl);
    @(posedge clk);
    #1;
    lookup_valid = lv;
    lookup_tag = lt;
    fill_valid = fv;
    fill_tag = ft;
    fill_ppn = fp;
    flush = fl;
  endtask

  initial begin
    fill_valid = 1;
    fill_tag = 29'h999;
    fill_ppn = 20'h55555;
    repeat (2) @(posedge clk);
    step(1, 29'h123, 0, 29'h0, 20'h0, 0);
    rst_n = 1;
    expect_v(F_HB, 0, 0); expect_v(F_HIT, 0, 0); expect_v(F_REP, 0, 0);
    expect_v(F_VB, 0, 0); expect_v(F_FR, 0, 1); expect_v(F_PPN, 0, 0);
    step(0, 29'h123, 1, 29'h123, 20'hABCDE, 0);
    expect_v(F_REP, 0, 0); expect_v(F_FR, 0, 1); expect_v(F_HB, 0, 0);
    step(1, 29'h123, 0, 29'h0, 20'h0, 0);
    expect_v(F_HB, 0, 8'h01); expect_v(F_HIT, 0, 1); expect_v(F_PPN, 0, 20'hABCDE);
    expect_v(F_VB, 0, 8'h01); expect_v(F_REP, 0, 1);
    step(0, 29'h0, 1, 29'h200, 20'h00002, 0);
    expect_v(F_REP, 0, 1);
    step(1, 29'h300, 1, 29'h300, 20'h00003, 0);
    expect_v(F_REP, 0, 2); expect_v(F_HB, 0, 8'h04); expect_v(F_HIT, 0, 1);
    step(0, 29'h0, 0, 29'h0, 20'h0, 0);
    expect_v(F_VB, 0, 8'h07); expect_v(F_PPN, 2, 20'h00003); expect_v(F_REP, 0, 3);
    for (int k = 0; k < 5; k++) begin
      step(0, 29'h0, 1, 29'(32'h400 + 32'h100 * k), 20'(k + 4), 0);
      expect_v(F_REP, 0, 32'(k + 3));
    end
    step(1, 29'h123, 1, 29'h900, 20'h00009, 0);
    expect_v(F_VB, 0, 8'hFF); expect_v(F_REP, 0, 0); expect_v(F_HB, 0, 8'h00); expect_v(F_HIT, 0, 0);
    step(1, 29'h900, 1, 29'hA00, 20'h0000A, 0);
    expect_v(F_REP, 0, 1); expect_v(F_HB, 0, 8'h01); expect_v(F_PPN, 0, 20'h00009);
    step(0, 29'h0, 0, 29'h0, 20'h0, 0);
    expect_v(F_PPN, 1, 20'h0000A); expect_v(F_PPN, 7, 20'h00008);
    step(1, 29'h600, 1, 29'h600, 20'h11111, 0);
    expect_v(F_REP, 0, 5); expect_v(F_HB, 0, 8'h20);
    step(1, 29'h600, 0, 29'h0, 20'h0, 0);
    expect_v(F_HB, 0, 8'h20); expect_v(F_PPN, 5, 20'h11111); expect_v(F_REP, 0, 2);
    step(0, 29'h0, 1, 29'hB00, 20'h0000B, 0);
    expect_v(F_REP, 0, 2);
    step(1, 29'h600, 1, 29'hC00, 20'h0000C, 1);
    expect_v(F_FR, 0, 0); expect_v(F_HB, 0, 8'h00); expect_v(F_HIT, 0, 0); expect_v(F_REP, 0, 3);
    step(1, 29'h600, 1, 29'hC00, 20'h0000C, 0);
    expect_v(F_VB, 0, 8'h00); expect_v(F_HB, 0, 8'h00); expect_v(F_REP, 0, 0);
    expect_v(F_FR, 0, 1); expect_v(F_PPN, 1, 20'h0000A); expect_v(F_PPN, 0, 20'h00009);
    step(1, 29'hC00, 0, 29'h0, 20'h0, 0);
    expect_v(F_VB, 0, 8'h01); expect_v(F_PPN, 0, 20'h0000C); expect_v(F_HB, 0, 8'h01);
    step(0, 29'h0, 0, 29'h0, 20'h0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
